// File: rtl/cache_pkg.sv
// Shared types for the cache miss/eviction interface: address geometry,
// fill-server state encoding and the captured miss-request record.
package cache_pkg;

  localparam int TAG_W  = 2;
  localparam int IDX_W  = 3;
  localparam int ADDR_W = TAG_W + IDX_W;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              evict;
    logic [ADDR_W-1:0] evict_addr;
    logic [DATA_W-1:0] evict_data;
  } req_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_fill_server.sv
// RAM-side responder for cache misses: optional victim write-back, then a
// read of the missing byte, returned to the cache controller over a handshake.
module cache_fill_server
  import cache_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_evict,
  input  logic [ADDR_W-1:0] req_evict_addr,
  input  logic [DATA_W-1:0] req_evict_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [CNT_W-1:0]  fill_count,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int                WAIT_W    = $clog2(RAM_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RAM_LAT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t            r_state;
  state_t            w_state_next;
  req_t              r_req;
  req_t              w_cur_req;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] w_ram_addr_next;
  logic [DATA_W-1:0] r_ram_data;
  logic [DATA_W-1:0] w_ram_data_next;
  logic              r_ram_wren;
  logic [ADDR_W-1:0] r_resp_addr;
  logic [DATA_W-1:0] r_resp_data;
  logic              w_accept;
  logic              w_consume;
  logic              w_wait_last;
  logic              w_wb_done;

  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_consume   = (r_state == RESP) && resp_ready;
  assign w_wait_last = (r_state == WAIT) && (r_wait_cnt == '0);
  assign w_wb_done   = (r_state == WB);

  // In IDLE the live request ports are the request; afterwards the captured copy is.
  always_comb begin
    w_cur_req = r_req;
    if (r_state == IDLE) begin
      w_cur_req.addr       = req_addr;
      w_cur_req.evict      = req_evict;
      w_cur_req.evict_addr = req_evict_addr;
      w_cur_req.evict_data = req_evict_data;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_ram_addr_next = r_ram_addr;
    w_ram_data_next = r_ram_data;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_next = w_cur_req.evict ? WB : RD;
        end
      end
      WB:   w_state_next = RD;
      RD:   w_state_next = WAIT;
      WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // RAM port registers are loaded on the edge that enters WB/RD so they are valid in that cycle.
    if (w_state_next == WB) begin
      w_ram_addr_next = w_cur_req.evict_addr;
      w_ram_data_next = w_cur_req.evict_data;
    end else if (w_state_next == RD) begin
      w_ram_addr_next = w_cur_req.addr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_wait_cnt  <= '0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_ram_wren  <= 1'b0;
      r_resp_addr <= '0;
      r_resp_data <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ram_addr <= w_ram_addr_next;
      r_ram_data <= w_ram_data_next;
      r_ram_wren <= (w_state_next == WB);
      if (w_accept) begin
        r_req <= w_cur_req;
      end
      if (r_state == RD) begin
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - WAIT_ONE;
      end
      if (w_wait_last) begin
        r_resp_data <= ram_q;
        r_resp_addr <= r_req.addr;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_fill_counter (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_consume),
    .o_count (fill_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_wb_counter (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_wb_done),
    .o_count (wb_count)
  );

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_addr  = r_resp_addr;
  assign resp_data  = r_resp_data;
  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign ram_wren   = r_ram_wren;

endmodule

// File: doc/cache_fill_server.md
Name: cache_fill_server

Overview:
Memory-side responder for the 2-way set-associative cache controller. It accepts one miss request per handshake. For each request it optionally writes back a dirty victim byte to the 32x8 synchronous RAM, then reads the missing byte and returns it to the cache controller. It is the RAM end of the cache miss/eviction interface and is the only block that drives the RAM port.

Parameters:
ADDR_W, 5, RAM byte address width (2-bit tag + 3-bit set index)
DATA_W, 8, data byte width
RAM_LAT, 1, cycles from the RAM address cycle to valid ram_q; legal values 1..3
CNT_W, 8, width of the statistics counters

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  miss request present
req_ready  out  1  server can accept a request
req_addr  in  ADDR_W  fill (miss) address
req_evict  in  1  dirty victim must be written back first
req_evict_addr  in  ADDR_W  victim address, formed as {victim tag, set index}
req_evict_data  in  DATA_W  victim data byte
resp_valid  out  1  fill data available
resp_ready  in  1  cache controller consumes the response
resp_addr  out  ADDR_W  address of the returned byte
resp_data  out  DATA_W  returned byte
ram_addr  out  ADDR_W  RAM address
ram_data  out  DATA_W  RAM write data
ram_wren  out  1  RAM write enable
ram_q  in  DATA_W  RAM read data
fill_count  out  CNT_W  completed fills, saturating
wb_count  out  CNT_W  completed write-backs, saturating

Behaviour:
- Reset: already decided — reset is asynchronous and active-high; clock is clock. On reset all outputs go to 0 except req_ready, which goes to 1. The FSM returns to IDLE, and counters and captured request registers clear. A reset during any state aborts the transaction immediately: ram_wren drops asynchronously and no response is produced.
- FSM states and transitions:
  - IDLE: req_ready=1. On the handshake (req_valid & req_ready, cycle N), latch req_addr, req_evict, req_evict_addr and req_evict_data. Go to WB if req_evict=1, otherwise go to RD.
  - WB: one cycle. ram_wren=1, ram_addr=evict_addr, ram_data=evict_data. wb_count increments. Go to RD.
  - RD: one cycle. ram_wren=0, ram_addr=fill addr. Go to WAIT.
  - WAIT: count RAM_LAT cycles. On the last cycle, capture ram_q into resp_data and the fill address into resp_addr. Go to RESP.
  - RESP: resp_valid=1, and resp_data/resp_addr are held stable. When resp_valid & resp_ready, fill_count increments and the FSM returns to IDLE.
- req_ready is 1 only in IDLE. There is no request pipelining: at most one transaction is outstanding.
- Latency, with no back-pressure:
  - Without evict: resp_valid is first high at cycle N+2+RAM_LAT.
  - With evict: resp_valid is first high at cycle N+3+RAM_LAT.
- ram_addr, ram_data and ram_wren are registered outputs. ram_wren is high only in WB. ram_data is a don't-care outside WB but is held at its last value.
- If req_evict_addr == req_addr, the write still precedes the read, so resp_data equals req_evict_data. This case is legal and needs no special handling.
- Inputs are ignored outside IDLE; changes on req_* after the handshake have no effect.
- resp_ready is ignored while resp_valid=0. The FSM may stall in RESP indefinitely.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Arithmetic: the WAIT counter is $clog2(RAM_LAT+1) bits wide and reloads on entry to WAIT.

Decomposition:
- Package cache_pkg holds:
  - ADDR_W, DATA_W, TAG_W=2, IDX_W=3;
  - the state enum {IDLE, WB, RD, WAIT, RESP};
  - a request struct {addr, evict, evict_addr, evict_data}.
- One sub-module is natural: sat_counter (CNT_W parameter, inc input, async reset). It is instanced twice, for fill_count and wb_count.
- The FSM stays in cache_fill_server.

Test Plan:
- Preload RAM[0x0B]=0x5A. Request addr 0x0B, evict=0, RAM_LAT=1 → ram_wren never high; resp_valid at N+3 with resp_data=0x5A, resp_addr=0x0B; fill_count=1, wb_count=0.
- Request addr 0x13, evict=1, evict_addr 0x03, evict_data 0xC4 → ram_wren=1 for exactly one cycle at N+1 with ram_addr=0x03, ram_data=0xC4; RAM[0x03]=0xC4 afterwards; resp at N+4 with RAM[0x13]; wb_count=1.
- Hold resp_ready=0 for 5 cycles → resp_valid and resp_data stay stable and req_ready=0; raise resp_ready → one-cycle consume, then req_ready=1 the next cycle.
- Evict and fill of the same address 0x07 with evict_data 0x99 → resp_data=0x99.
- Assert reset during WAIT → all outputs clear immediately, no resp_valid, counters=0; a fresh request afterwards completes normally.
- Issue 260 back-to-back fills with CNT_W=8 → fill_count saturates at 255. Repeat with RAM_LAT=3 → latency becomes N+5.
